// File: rtl/wb_commit_queue_if.sv
`default_nettype none
// ============================================================================
// wb_commit_queue_if : enqueue lanes and register-file write ports
// Rev 1.0
// ============================================================================
interface wb_commit_queue_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid0;
  logic          in_valid1;
  logic [5:0]    in_addr0;
  logic [5:0]    in_addr1;
  logic [63:0]   in_data0;
  logic [63:0]   in_data1;
  logic          in_ready;

  logic          we0, we1, we2, we3;
  logic [5:0]    waddr0, waddr1, waddr2, waddr3;
  logic [63:0]   wdata0, wdata1, wdata2, wdata3;
  logic [CW-1:0] occupancy;
  logic          empty;

  modport master (
    output in_valid0, in_valid1, in_addr0, in_addr1, in_data0, in_data1,
    input  in_ready,
    input  we0, we1, we2, we3,
    input  waddr0, waddr1, waddr2, waddr3,
    input  wdata0, wdata1, wdata2, wdata3,
    input  occupancy, empty
  );

  modport slave (
    input  in_valid0, in_valid1, in_addr0, in_addr1, in_data0, in_data1,
    output in_ready,
    output we0, we1, we2, we3,
    output waddr0, waddr1, waddr2, waddr3,
    output wdata0, wdata1, wdata2, wdata3,
    output occupancy, empty
  );
endinterface
`default_nettype wire

// File: rtl/wb_commit_queue.sv
`default_nettype none
// ============================================================================
// wb_commit_queue : 2-in / 4-out in-order writeback queue feeding the regfile
// Rev 1.0
// ============================================================================
module wb_commit_queue #(
  parameter int DEPTH = 8
) (
  input  wire logic        clk,
  input  wire logic        resetn,
  wb_commit_queue_if.slave bus
);
  localparam int          AW   = $clog2(DEPTH);
  localparam int          CW   = AW + 1;
  localparam logic [5:0]  HILO = 6'd32;

  logic [5:0]    mem_addr_q [DEPTH];
  logic [63:0]   mem_data_q [DEPTH];

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [3:0]    we_q, we_d;
  logic [5:0]    waddr_q [4];
  logic [5:0]    waddr_d [4];
  logic [63:0]   wdata_q [4];
  logic [63:0]   wdata_d [4];

  logic          in_ready;
  logic          acc0, acc1;
  logic [1:0]    n_enq;
  logic [2:0]    n_deq;
  logic [3:0]    sel;
  logic          chain, ok;
  logic [5:0]    ent_addr [4];
  logic [63:0]   ent_data [4];

  // Only the registered count gates acceptance, keeping in_ready off the drain path.
  assign in_ready = (count_q <= CW'(DEPTH - 2));
  assign acc0     = in_ready && bus.in_valid0;
  assign acc1     = in_ready && bus.in_valid1;
  assign n_enq    = {1'b0, acc0} + {1'b0, acc1};

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      ent_addr[k] = mem_addr_q[head_q + AW'(k)];
      ent_data[k] = mem_data_q[head_q + AW'(k)];
    end
  end

  // Prefix selection: HI/LO only on lane 0, no repeated nonzero address in a group.
  always_comb begin
    sel   = '0;
    chain = 1'b1;
    ok    = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ok = chain && (CW'(k) < count_q) && ((k == 0) || (ent_addr[k] != HILO));
      for (int j = 0; j < k; j++) begin
        if ((ent_addr[k] != 6'd0) && (ent_addr[k] == ent_addr[j])) ok = 1'b0;
      end
      sel[k] = ok;
      chain  = ok;
    end
  end

  assign n_deq = {2'b0, sel[0]} + {2'b0, sel[1]} + {2'b0, sel[2]} + {2'b0, sel[3]};

  always_comb begin
    head_d  = head_q + AW'(n_deq);
    tail_d  = tail_q + AW'(n_enq);
    count_d = count_q + CW'(n_enq) - CW'(n_deq);
    for (int k = 0; k < 4; k++) begin
      we_d[k]    = sel[k] && (ent_addr[k] != 6'd0);
      waddr_d[k] = sel[k] ? ent_addr[k] : waddr_q[k];
      wdata_d[k] = sel[k] ? ent_data[k] : wdata_q[k];
    end
  end

  // Storage has no reset; entries beyond count are never observed.
  always_ff @(posedge clk) begin
    if (acc0) begin
      mem_addr_q[tail_q] <= bus.in_addr0;
      mem_data_q[tail_q] <= bus.in_data0;
    end
    if (acc1) begin
      mem_addr_q[tail_q + AW'(acc0)] <= bus.in_addr1;
      mem_data_q[tail_q + AW'(acc0)] <= bus.in_data1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      we_q    <= '0;
      for (int k = 0; k < 4; k++) begin
        waddr_q[k] <= '0;
        wdata_q[k] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      we_q    <= we_d;
      for (int k = 0; k < 4; k++) begin
        waddr_q[k] <= waddr_d[k];
        wdata_q[k] <= wdata_d[k];
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.occupancy = count_q;
  assign bus.empty     = (count_q == '0);
  assign bus.we0       = we_q[0];
  assign bus.we1       = we_q[1];
  assign bus.we2       = we_q[2];
  assign bus.we3       = we_q[3];
  assign bus.waddr0    = waddr_q[0];
  assign bus.waddr1    = waddr_q[1];
  assign bus.waddr2    = waddr_q[2];
  assign bus.waddr3    = waddr_q[3];
  assign bus.wdata0    = wdata_q[0];
  assign bus.wdata1    = wdata_q[1];
  assign bus.wdata2    = wdata_q[2];
  assign bus.wdata3    = wdata_q[3];
endmodule
`default_nettype wire

// File: tb/tb_wb_commit_queue.sv
`default_nettype none
// ============================================================================
// tb_wb_commit_queue : randomized bench with a queue-based reference model
// Rev 1.0
// ============================================================================
module tb_wb_commit_queue;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  wb_commit_queue_if #(.DEPTH(DEPTH)) bus ();
  wb_commit_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  typedef struct packed {
    logic [5:0]  addr;
    logic [63:0] data;
  } ent_t;

  ent_t        mq[$];
  logic        exp_we    [4];
  logic [5:0]  exp_waddr [4];
  logic [63:0] exp_wdata [4];
  logic        obs_we    [4];
  logic [5:0]  obs_waddr [4];
  logic [63:0] obs_wdata [4];
  int          errors = 0;
  int          checks = 0;
  bit          last_acc;
  int          enq_total = 0;

  always_comb begin
    obs_we[0] = bus.we0;  obs_waddr[0] = bus.waddr0;  obs_wdata[0] = bus.wdata0;
    obs_we[1] = bus.we1;  obs_waddr[1] = bus.waddr1;  obs_wdata[1] = bus.wdata1;
    obs_we[2] = bus.we2;  obs_waddr[2] = bus.waddr2;  obs_wdata[2] = bus.wdata2;
    obs_we[3] = bus.we3;  obs_waddr[3] = bus.waddr3;  obs_wdata[3] = bus.wdata3;
  end

  task automatic model_reset();
    mq.delete();
    for (int k = 0; k < 4; k++) begin
      exp_we[k] = 1'b0; exp_waddr[k] = '0; exp_wdata[k] = '0;
    end
  endtask

  // Drive one cycle of input, update the model from the rules, clock the DUT.
  task automatic advance(input bit v0, input logic [5:0] a0, input logic [63:0] d0,
                         input bit v1, input logic [5:0] a1, input logic [63:0] d1);
    bit   rdy, stop;
    int   n;
    ent_t e;
    bus.in_valid0 = v0; bus.in_addr0 = a0; bus.in_data0 = d0;
    bus.in_valid1 = v1; bus.in_addr1 = a1; bus.in_data1 = d1;
    rdy  = (DEPTH - mq.size()) >= 2;
    n    = 0;
    stop = 1'b0;
    for (int k = 0; k < 4; k++) exp_we[k] = 1'b0;
    while (!stop && n < 4 && n < mq.size()) begin
      if (mq[n].addr == 6'd32 && n > 0) stop = 1'b1;
      for (int j = 0; j < n; j++)
        if (mq[n].addr != 6'd0 && mq[n].addr == mq[j].addr) stop = 1'b1;
      if (!stop) begin
        exp_we[n]    = (mq[n].addr != 6'd0);
        exp_waddr[n] = mq[n].addr;
        exp_wdata[n] = mq[n].data;
        n++;
      end
    end
    repeat (n) void'(mq.pop_front());
    if (rdy && v0) begin e.addr = a0; e.data = d0; mq.push_back(e); enq_total++; end
    if (rdy && v1) begin e.addr = a1; e.data = d1; mq.push_back(e); enq_total++; end
    last_acc = rdy;
    @(posedge clk); #1;
    bus.in_valid0 = 1'b0;
    bus.in_valid1 = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (obs_we[k] !== 1'b0 || obs_waddr[k] !== 6'd0 || obs_wdata[k] !== 64'd0) begin
        errors++;
        $display("FAIL reset port%0d: got we=%0b addr=%0d data=%h, want zeros",
                 k, obs_we[k], obs_waddr[k], obs_wdata[k]);
      end
    end
    resetn = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.empty !== 1'b1 || bus.occupancy !== CW'(0)) begin
      errors++;
      $display("FAIL reset status: got ready=%0b empty=%0b occ=%0d, want 1 1 0",
               bus.in_ready, bus.empty, bus.occupancy);
    end
  endtask

  task automatic test_single();
    advance(1'b1, 6'd5, 64'h1234, 1'b0, 6'd0, 64'd0);
    checks++;
    if (bus.occupancy !== CW'(1) || bus.we0 !== 1'b0) begin
      errors++;
      $display("FAIL single_accept: got occ=%0d we0=%0b, want 1 0", bus.occupancy, bus.we0);
    end
    advance(1'b0, 6'd0, 64'd0, 1'b0, 6'd0, 64'd0);
    checks++;
    if (bus.we0 !== 1'b1 || bus.waddr0 !== 6'd5 || bus.wdata0[31:0] !== 32'h1234 ||
        {bus.we1, bus.we2, bus.we3} !== 3'b000 || bus.empty !== 1'b1) begin
      errors++;
      $display("FAIL single_drain: got we=%b%b%b%b addr0=%0d data0=%h empty=%0b, want 0001 5 1234 1",
               bus.we3, bus.we2, bus.we1, bus.we0, bus.waddr0, bus.wdata0, bus.empty);
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 6; c++) begin
      if (c < 4)
        advance(1'b1, 6'(2*c+1), {$urandom, $urandom}, 1'b1, 6'(2*c+2), {$urandom, $urandom});
      else
        advance(1'b0, 6'd0, 64'd0, 1'b0, 6'd0, 64'd0);
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (obs_we[k] !== exp_we[k] || obs_waddr[k] !== exp_waddr[k] || obs_wdata[k] !== exp_wdata[k]) begin
          errors++;
          $display("FAIL b2b cyc%0d port%0d: got we=%0b addr=%0d data=%h, want we=%0b addr=%0d data=%h",
                   c, k, obs_we[k], obs_waddr[k], obs_wdata[k], exp_we[k], exp_waddr[k], exp_wdata[k]);
        end
      end
      checks++;
      if (bus.in_ready !== 1'b1 || bus.occupancy > CW'(2) || bus.occupancy !== CW'(mq.size())) begin
        errors++;
        $display("FAIL b2b_status cyc%0d: got ready=%0b occ=%0d, want 1 %0d",
                 c, bus.in_ready, bus.occupancy, mq.size());
      end
    end
  endtask

  task automatic test_same_reg_order();
    logic [63:0] d_old, d_new;
    d_old = {$urandom, $urandom};
    d_new = {$urandom, $urandom};
    advance(1'b1, 6'd3, {$urandom, $urandom}, 1'b1, 6'd3, {$urandom, $urandom});
    advance(1'b1, 6'd3, d_old, 1'b1, 6'd7, 64'h77);
    advance(1'b1, 6'd3, d_new, 1'b1, 6'd9, 64'h99);
    advance(1'b0, 6'd0, 64'd0, 1'b0, 6'd0, 64'd0);
    checks++;
    if ({bus.we3, bus.we2, bus.we1, bus.we0} !== 4'b0011 || bus.waddr0 !== 6'd3 ||
        bus.wdata0 !== d_old || bus.waddr1 !== 6'd7) begin
      errors++;
      $display("FAIL raw_first: got we=%b%b%b%b a0=%0d d0=%h a1=%0d, want 0011 3 %h 7",
               bus.we3, bus.we2, bus.we1, bus.we0, bus.waddr0, bus.wdata0, bus.waddr1, d_old);
    end
    advance(1'b0, 6'd0, 64'd0, 1'b0, 6'd0, 64'd0);
    checks++;
    if ({bus.we3, bus.we2, bus.we1, bus.we0} !== 4'b0011 || bus.waddr0 !== 6'd3 ||
        bus.wdata0 !== d_new || bus.waddr1 !== 6'd9 || bus.empty !== 1'b1) begin
      errors++;
      $display("FAIL raw_second: got we=%b%b%b%b a0=%0d d0=%h a1=%0d empty=%0b, want 0011 3 %h 9 1",
               bus.we3, bus.we2, bus.we1, bus.we0, bus.waddr0, bus.wdata0, bus.waddr1, bus.empty, d_new);
    end
  endtask

  task automatic test_hilo();
    advance(1'b1, 6'd4, 64'h44, 1'b1, 6'd32, 64'hAAAA_BBBB_CCCC_DDDD);
    advance(1'b1, 6'd6, 64'h66, 1'b0, 6'd0, 64'd0);
    checks++;
    if ({bus.we3, bus.we2, bus.we1, bus.we0} !== 4'b0001 || bus.waddr0 !== 6'd4) begin
      errors++;
      $display("FAIL hilo_wait: got we=%b%b%b%b a0=%0d, want 0001 4",
               bus.we3, bus.we2, bus.we1, bus.we0, bus.waddr0);
    end
    advance(1'b0, 6'd0, 64'd0, 1'b0, 6'd0, 64'd0);
    checks++;
    if ({bus.we3, bus.we2, bus.we1, bus.we0} !== 4'b0011 || bus.waddr0 !== 6'd32 ||
        bus.wdata0 !== 64'hAAAA_BBBB_CCCC_DDDD || bus.waddr1 !== 6'd6 || bus.wdata1 !== 64'h66) begin
      errors++;
      $display("FAIL hilo_issue: got we=%b%b%b%b a0=%0d d0=%h a1=%0d d1=%h, want 0011 32 aaaabbbbccccdddd 6 66",
               bus.we3, bus.we2, bus.we1, bus.we0, bus.waddr0, bus.wdata0, bus.waddr1, bus.wdata1);
    end
  endtask

  function automatic logic [5:0] pick_addr(input bit stall);
    int r;
    r = $urandom_range(0, 7);
    if (stall) return (r < 5) ? 6'd10 : ((r < 7) ? 6'd32 : 6'd0);
    if (r == 0) return 6'd0;
    if (r == 1) return 6'd32;
    return 6'($urandom_range(1, 31));
  endfunction

  task automatic test_fill_wrap();
    bit          saw_full = 1'b0;
    int          start_enq;
    bit          v0, v1;
    logic [5:0]  a0, a1;
    logic [63:0] d0, d1;
    start_enq = enq_total;
    last_acc  = 1'b1;
    v0 = 0; v1 = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0;
    for (int c = 0; c < 240; c++) begin
      if (last_acc) begin
        v0 = ($urandom_range(0, 9) != 0); a0 = pick_addr(((c / 40) % 2) == 0); d0 = {$urandom, $urandom};
        v1 = ($urandom_range(0, 9) != 0); a1 = pick_addr(((c / 40) % 2) == 0); d1 = {$urandom, $urandom};
      end
      advance(v0, a0, d0, v1, a1, d1);
      if (bus.in_ready === 1'b0) saw_full = 1'b1;
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (obs_we[k] !== exp_we[k] || obs_waddr[k] !== exp_waddr[k] || obs_wdata[k] !== exp_wdata[k]) begin
          errors++;
          $display("FAIL fill cyc%0d port%0d: got we=%0b addr=%0d data=%h, want we=%0b addr=%0d data=%h",
                   c, k, obs_we[k], obs_waddr[k], obs_wdata[k], exp_we[k], exp_waddr[k], exp_wdata[k]);
        end
      end
      checks++;
      if (bus.in_ready !== ((DEPTH - mq.size()) >= 2) || bus.occupancy !== CW'(mq.size()) ||
          bus.empty !== (mq.size() == 0)) begin
        errors++;
        $display("FAIL fill_status cyc%0d: got ready=%0b occ=%0d empty=%0b, want occ=%0d",
                 c, bus.in_ready, bus.occupancy, bus.empty, mq.size());
      end
    end
    checks++;
    if (saw_full !== 1'b1 || (enq_total - start_enq) < 3 * DEPTH) begin
      errors++;
      $display("FAIL fill_coverage: got saw_full=%0b enq=%0d, want 1 and >=%0d",
               saw_full, enq_total - start_enq, 3 * DEPTH);
    end
    repeat (6) advance(1'b0, 6'd0, 64'd0, 1'b0, 6'd0, 64'd0);
  endtask

  task automatic test_reset_mid();
    advance(1'b1, 6'd3, 64'h1, 1'b1, 6'd3, 64'h2);
    advance(1'b1, 6'd3, 64'h3, 1'b1, 6'd3, 64'h4);
    advance(1'b1, 6'd3, 64'h5, 1'b1, 6'd4, 64'h6);
    advance(1'b1, 6'd3, 64'h7, 1'b1, 6'd4, 64'h8);
    advance(1'b1, 6'd3, 64'h9, 1'b1, 6'd4, 64'hA);
    advance(1'b1, 6'd3, 64'hB, 1'b0, 6'd0, 64'd0);
    checks++;
    if (bus.occupancy !== CW'(5) || bus.we1 !== 1'b1 || bus.we0 !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre: got occ=%0d we0=%0b we1=%0b, want 5 1 1",
               bus.occupancy, bus.we0, bus.we1);
    end
    #2 resetn = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({bus.we3, bus.we2, bus.we1, bus.we0} !== 4'b0000 || bus.occupancy !== CW'(0) ||
        bus.in_ready !== 1'b1 || bus.empty !== 1'b1) begin
      errors++;
      $display("FAIL midrst_async: got we=%b%b%b%b occ=%0d ready=%0b empty=%0b, want 0000 0 1 1",
               bus.we3, bus.we2, bus.we1, bus.we0, bus.occupancy, bus.in_ready, bus.empty);
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    advance(1'b0, 6'd0, 64'd0, 1'b0, 6'd0, 64'd0);
    checks++;
    if ({bus.we3, bus.we2, bus.we1, bus.we0} !== 4'b0000 || bus.occupancy !== CW'(0) ||
        bus.in_ready !== 1'b1 || bus.waddr1 !== 6'd0) begin
      errors++;
      $display("FAIL midrst_release: got we=%b%b%b%b occ=%0d ready=%0b waddr1=%0d, want 0000 0 1 0",
               bus.we3, bus.we2, bus.we1, bus.we0, bus.occupancy, bus.in_ready, bus.waddr1);
    end
  endtask

  initial begin
    bus.in_valid0 = 1'b0; bus.in_addr0 = '0; bus.in_data0 = '0;
    bus.in_valid1 = 1'b0; bus.in_addr1 = '0; bus.in_data1 = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_same_reg_order();
    test_hilo();
    test_fill_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
